// File: rtl/divider_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : divider_pkg
//  Description : Shared types and helpers for the restoring divider.
//  Revision    : 1.0  initial release
// ============================================================================
package divider_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } div_state_t;

    // Bits needed for an iteration counter that must hold the value n.
    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage : divider_pkg
`default_nettype wire

// File: rtl/shifter_left.sv
`default_nettype none
// ============================================================================
//  Module      : shifter_left
//  Description : Left-shift register with parallel load. Serial data enters
//                at the LSB, the MSB is presented as serial_out. Load takes
//                priority over shift.
//  Revision    : 1.0  initial release
// ============================================================================
module shifter_left #(
    parameter int WIDTH = 8
) (
    input  logic             CLOCK,
    input  logic             RESET,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_data,
    input  logic             i_enable,
    input  logic             i_serial_in,
    output logic [WIDTH-1:0] o_data,
    output logic             o_serial_out
);

    logic [WIDTH-1:0] r_data;

    // Parallel load or one-bit left shift, cleared by asynchronous reset.
    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            r_data <= '0;
        end else if (i_load) begin
            r_data <= i_load_data;
        end else if (i_enable) begin
            r_data <= {r_data[WIDTH-2:0], i_serial_in};
        end
    end

    assign o_data       = r_data;
    assign o_serial_out = r_data[WIDTH-1];

endmodule : shifter_left
`default_nettype wire

// File: rtl/restoring_divider.sv
`default_nettype none
// ============================================================================
//  Module      : restoring_divider
//  Description : Unsigned sequential restoring divider. The {R,Q} pair shifts
//                left once per cycle; the divisor is trial-subtracted from the
//                shifted remainder and the result is kept only when it does
//                not borrow. Start/busy/done handshake, results held until
//                the next accepted START.
//  Revision    : 1.0  initial release
// ============================================================================
module restoring_divider #(
    parameter int size = 8
) (
    input  logic            CLOCK,
    input  logic            RESET,
    input  logic            START,
    input  logic [size-1:0] dividend,
    input  logic [size-1:0] divisor,
    output logic [size-1:0] quotient,
    output logic [size-1:0] remainder,
    output logic            BUSY,
    output logic            DONE,
    output logic            div_by_zero
);

    import divider_pkg::*;

    localparam int CW = cnt_width(size);

    div_state_t      r_state;
    div_state_t      w_next_state;
    logic [CW-1:0]   r_cnt;
    logic [size-1:0] r_div;

    logic [size:0]   w_r;
    logic [size-1:0] w_q;
    logic            w_q_msb;
    logic            w_r_serial_out;
    logic [size:0]   w_r_shift;
    logic [size:0]   w_trial;
    logic [size:0]   w_r_next;
    logic [size-1:0] w_q_next;
    logic            w_borrow;
    logic            w_accept;
    logic            w_calc;
    logic            w_last;
    logic            w_unused;

    assign w_calc   = (r_state == divider_pkg::CALC);
    assign w_accept = START && ((r_state == divider_pkg::IDLE) || (r_state == divider_pkg::DONE));
    assign w_last   = w_calc && (r_cnt == CW'(1));

    // R is one bit wider than the operands so the borrow of the trial
    // subtraction appears directly in its MSB.
    assign w_r_shift = {w_r[size-1:0], w_q_msb};
    assign w_trial   = w_r_shift - {1'b0, r_div};
    assign w_borrow  = w_trial[size];
    assign w_r_next  = w_borrow ? w_r_shift : w_trial;
    assign w_q_next  = {w_q[size-2:0], ~w_borrow};

    // The top R bit is always 0 once an iteration has completed (R < D).
    assign w_unused  = ^{w_r[size], w_r_next[size], w_r_serial_out};

    // Remainder half: loads zero on capture, loads the trial difference when
    // it does not borrow, otherwise shifts in Q's MSB (the restore case).
    shifter_left #(.WIDTH(size + 1)) u_rem (
        .CLOCK        (CLOCK),
        .RESET        (RESET),
        .i_load       (w_accept || (w_calc && !w_borrow)),
        .i_load_data  (w_accept ? '0 : w_trial),
        .i_enable     (w_calc),
        .i_serial_in  (w_q_msb),
        .o_data       (w_r),
        .o_serial_out (w_r_serial_out)
    );

    // Quotient half: starts as the dividend, new quotient bits enter at LSB.
    shifter_left #(.WIDTH(size)) u_quo (
        .CLOCK        (CLOCK),
        .RESET        (RESET),
        .i_load       (w_accept),
        .i_load_data  (dividend),
        .i_enable     (w_calc),
        .i_serial_in  (~w_borrow),
        .o_data       (w_q),
        .o_serial_out (w_q_msb)
    );

    // State register.
    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            r_state <= divider_pkg::IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic and status outputs decoded from the state.
    always_comb begin
        w_next_state = r_state;
        BUSY         = 1'b0;
        DONE         = 1'b0;
        case (r_state)
            divider_pkg::IDLE: begin
                if (START) w_next_state = divider_pkg::CALC;
            end
            divider_pkg::CALC: begin
                BUSY = 1'b1;
                if (w_last) w_next_state = divider_pkg::DONE;
            end
            divider_pkg::DONE: begin
                DONE         = 1'b1;
                w_next_state = START ? divider_pkg::CALC : divider_pkg::IDLE;
            end
            default: w_next_state = divider_pkg::IDLE;
        endcase
    end

    // Divisor capture and iteration counter.
    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            r_div <= '0;
            r_cnt <= '0;
        end else if (w_accept) begin
            r_div <= divisor;
            r_cnt <= CW'(size);
        end else if (w_calc) begin
            r_cnt <= r_cnt - CW'(1);
        end
    end

    // Result registers: written only on the final iteration edge.
    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else if (w_accept) begin
            div_by_zero <= 1'b0;
        end else if (w_last) begin
            quotient    <= w_q_next;
            remainder   <= w_r_next[size-1:0];
            div_by_zero <= (r_div == '0);
        end
    end

endmodule : restoring_divider
`default_nettype wire

// File: tb/tb_restoring_divider.sv
`default_nettype none
// ============================================================================
//  Module      : tb_restoring_divider
//  Description : Scoreboard bench for restoring_divider (size=8 and size=16).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_restoring_divider;

    typedef struct {
        logic [15:0] q;
        logic [15:0] r;
        logic        dz;
    } exp_t;

    logic        CLOCK = 1'b0;
    logic        RESET = 1'b0;

    logic        s8 = 1'b0;
    logic [7:0]  a8 = '0, b8 = '0, q8, r8;
    logic        busy8, done8, dz8;

    logic        s16 = 1'b0;
    logic [15:0] a16 = '0, b16 = '0, q16, r16;
    logic        busy16, done16, dz16;

    exp_t sb8[$];
    exp_t sb16[$];
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 CLOCK = ~CLOCK;

    restoring_divider #(.size(8)) u_dut8 (
        .CLOCK(CLOCK), .RESET(RESET), .START(s8), .dividend(a8), .divisor(b8),
        .quotient(q8), .remainder(r8), .BUSY(busy8), .DONE(done8), .div_by_zero(dz8)
    );

    restoring_divider #(.size(16)) u_dut16 (
        .CLOCK(CLOCK), .RESET(RESET), .START(s16), .dividend(a16), .divisor(b16),
        .quotient(q16), .remainder(r16), .BUSY(busy16), .DONE(done16), .div_by_zero(dz16)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    function automatic exp_t model(input logic [15:0] a, input logic [15:0] b, input int w);
        exp_t e;
        logic [15:0] ones;
        ones = (w == 8) ? 16'h00FF : 16'hFFFF;
        if (b == 0) begin
            e.q = ones; e.r = a; e.dz = 1'b1;
        end else begin
            e.q = a / b; e.r = a % b; e.dz = 1'b0;
        end
        return e;
    endfunction

    // Scoreboard: every DONE pulse pops one expected result.
    always @(negedge CLOCK) begin
        if (RESET && done8) begin
            check("dut8 busy with done", busy8, 0);
            if (sb8.size() == 0) check("dut8 spurious DONE", done8, 0);
            else begin
                exp_t e;
                e = sb8.pop_front();
                check("dut8 quotient", q8, e.q);
                check("dut8 remainder", r8, e.r);
                check("dut8 div_by_zero", dz8, e.dz);
            end
        end
        if (RESET && done16) begin
            if (sb16.size() == 0) check("dut16 spurious DONE", done16, 0);
            else begin
                exp_t e;
                e = sb16.pop_front();
                check("dut16 quotient", q16, e.q);
                check("dut16 remainder", r16, e.r);
                check("dut16 div_by_zero", dz16, e.dz);
            end
        end
    end

    // Drive one START pulse; returns at the negedge after the accepting edge.
    task automatic go8(input logic [7:0] a, input logic [7:0] b);
        @(negedge CLOCK);
        a8 = a; b8 = b; s8 = 1'b1;
        sb8.push_back(model({8'd0, a}, {8'd0, b}, 8));
        @(negedge CLOCK);
        s8 = 1'b0;
    endtask

    task automatic wait8();
        for (int i = 0; i < 40; i++) begin
            if (done8) return;
            @(negedge CLOCK);
        end
        check("dut8 timeout", done8, 1);
    endtask

    task automatic run8(input logic [7:0] a, input logic [7:0] b);
        go8(a, b);
        wait8();
    endtask

    task automatic run16(input logic [15:0] a, input logic [15:0] b);
        @(negedge CLOCK);
        a16 = a; b16 = b; s16 = 1'b1;
        sb16.push_back(model(a, b, 16));
        @(negedge CLOCK);
        s16 = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (done16) return;
            @(negedge CLOCK);
        end
        check("dut16 timeout", done16, 1);
    endtask

    initial begin
        int period;

        // Reset state
        repeat (2) @(negedge CLOCK);
        check("rst quotient", q8, 0);
        check("rst remainder", r8, 0);
        check("rst busy", busy8, 0);
        check("rst done", done8, 0);
        check("rst dz", dz8, 0);
        RESET = 1'b1;

        // 100/7 with exact latency
        go8(8'd100, 8'd7);
        for (int i = 0; i < 8; i++) begin
            check("latency busy", busy8, 1);
            check("latency no done", done8, 0);
            @(negedge CLOCK);
        end
        check("latency done", done8, 1);
        @(negedge CLOCK);
        check("done single cycle", done8, 0);

        run8(8'd255, 8'd1);
        run8(8'd0, 8'd5);
        run8(8'd5, 8'd9);
        run8(8'd200, 8'd0);
        @(negedge CLOCK);
        check("dz held", dz8, 1);
        go8(8'd10, 8'd3);
        check("dz cleared on capture", dz8, 0);
        wait8();

        // START during CALC is ignored
        go8(8'd100, 8'd7);
        repeat (3) @(negedge CLOCK);
        a8 = 8'd50; b8 = 8'd3; s8 = 1'b1;
        @(negedge CLOCK);
        s8 = 1'b0;
        wait8();
        repeat (15) @(negedge CLOCK);

        // Back-to-back with START held high
        @(negedge CLOCK);
        a8 = 8'd100; b8 = 8'd7; s8 = 1'b1;
        sb8.push_back(model(16'd100, 16'd7, 8));
        @(negedge CLOCK);
        wait8();
        a8 = 8'd45; b8 = 8'd4;
        sb8.push_back(model(16'd45, 16'd4, 8));
        period = 0;
        do begin
            @(negedge CLOCK);
            period++;
        end while (!done8 && period < 40);
        check("b2b period", period, 9);
        a8 = 8'd255; b8 = 8'd16;
        sb8.push_back(model(16'd255, 16'd16, 8));
        @(negedge CLOCK);
        s8 = 1'b0;
        wait8();
        @(negedge CLOCK);

        // Reset in the 4th CALC cycle
        go8(8'd100, 8'd7);
        repeat (3) @(negedge CLOCK);
        RESET = 1'b0;
        #1;
        sb8.delete();
        check("midrst quotient", q8, 0);
        check("midrst remainder", r8, 0);
        check("midrst busy", busy8, 0);
        check("midrst done", done8, 0);
        repeat (2) @(negedge CLOCK);
        RESET = 1'b1;
        repeat (15) @(negedge CLOCK);
        run8(8'd77, 8'd8);

        // size=16 regression
        run16(16'd1234, 16'd0);
        run16(16'd65535, 16'd1);
        run16(16'd777, 16'd777);
        run16(16'd65535, 16'd65535);
        run16(16'd65535, 16'd3);
        run16(16'd0, 16'd0);
        for (int i = 0; i < 30; i++) begin
            run16(16'($urandom), 16'($urandom_range(0, 300)));
        end

        repeat (3) @(negedge CLOCK);
        check("dut8 scoreboard empty", sb8.size(), 0);
        check("dut16 scoreboard empty", sb16.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_restoring_divider
`default_nettype wire
